// File: rtl/pipe_ctrl_decoder_pkg.sv
// Shared decode definitions for the ID->EX control decoder: opcodes, ex_ctrl
// field positions, ALU/output-select codes and the opcode/function decoder.
package ctrl_pkg;

    localparam int unsigned OP_W   = 6;
    localparam int unsigned CTRL_W = 18;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [OP_W-1:0] OP_J     = 6'h02;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
    localparam logic [OP_W-1:0] OP_BNE   = 6'h05;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
    localparam logic [OP_W-1:0] OP_ADDIU = 6'h09;
    localparam logic [OP_W-1:0] OP_SLTI  = 6'h0A;
    localparam logic [OP_W-1:0] OP_SLTIU = 6'h0B;
    localparam logic [OP_W-1:0] OP_ANDI  = 6'h0C;
    localparam logic [OP_W-1:0] OP_ORI   = 6'h0D;
    localparam logic [OP_W-1:0] OP_XORI  = 6'h0E;
    localparam logic [OP_W-1:0] OP_LUI   = 6'h0F;
    localparam logic [OP_W-1:0] OP_LW    = 6'h23;
    localparam logic [OP_W-1:0] OP_SW    = 6'h2B;

    localparam logic [OP_W-1:0] FN_NOP   = 6'h00;
    localparam logic [OP_W-1:0] FN_MFHI  = 6'h10;
    localparam logic [OP_W-1:0] FN_MFLO  = 6'h12;
    localparam logic [OP_W-1:0] FN_MULT  = 6'h18;
    localparam logic [OP_W-1:0] FN_MULTU = 6'h19;

    localparam int unsigned F_RW    = 17;
    localparam int unsigned F_RD    = 16;
    localparam int unsigned F_A     = 15;
    localparam int unsigned F_MID   = 12;
    localparam int unsigned F_MW    = 11;
    localparam int unsigned F_MR    = 10;
    localparam int unsigned F_M2R   = 9;
    localparam int unsigned F_BEQ   = 8;
    localparam int unsigned F_BNE   = 7;
    localparam int unsigned F_JUMP  = 6;
    localparam int unsigned F_SE    = 5;
    localparam int unsigned F_OUT   = 3;
    localparam int unsigned F_START = 2;
    localparam int unsigned F_SIGN  = 1;
    localparam int unsigned F_ILL   = 0;

    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;
    localparam logic [2:0] ALU_R   = 3'b111;

    localparam logic [1:0] OUT_LUI = 2'b01;
    localparam logic [1:0] OUT_LO  = 2'b10;
    localparam logic [1:0] OUT_HI  = 2'b11;

    function automatic logic is_legal(input logic [OP_W-1:0] op);
        case (op)
            OP_RTYPE, OP_J, OP_BEQ, OP_BNE, OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
            OP_ANDI, OP_ORI, OP_XORI, OP_LUI, OP_LW, OP_SW: is_legal = 1'b1;
            default:                                        is_legal = 1'b0;
        endcase
    endfunction

    // Instructions that touch HI/LO and must wait for the multiplier.
    function automatic logic is_mult_class(input logic [OP_W-1:0] op, input logic [OP_W-1:0] func);
        is_mult_class = (op == OP_RTYPE) &&
                        (func == FN_MFHI || func == FN_MFLO || func == FN_MULT || func == FN_MULTU);
    endfunction

    function automatic logic [CTRL_W-1:0] decode(input logic [OP_W-1:0] op,
                                                 input logic [OP_W-1:0] func,
                                                 input logic trap);
        logic [CTRL_W-1:0] c;
        c = '0;
        case (op)
            OP_RTYPE: begin
                case (func)
                    FN_NOP:   ;
                    FN_MFHI:  begin c[F_RW] = 1'b1; c[F_RD] = 1'b1; c[F_OUT +: 2] = OUT_HI; end
                    FN_MFLO:  begin c[F_RW] = 1'b1; c[F_RD] = 1'b1; c[F_OUT +: 2] = OUT_LO; end
                    FN_MULT:  begin c[F_START] = 1'b1; c[F_SIGN] = 1'b1; end
                    FN_MULTU: c[F_START] = 1'b1;
                    default:  begin c[F_RW] = 1'b1; c[F_RD] = 1'b1; c[F_MID +: 3] = ALU_R; end
                endcase
            end
            OP_J:     c[F_JUMP] = 1'b1;
            OP_BEQ:   c[F_BEQ]  = 1'b1;
            OP_BNE:   c[F_BNE]  = 1'b1;
            OP_ADDI, OP_ADDIU: begin c[F_RW] = 1'b1; c[F_A] = 1'b1; c[F_SE] = 1'b1; end
            OP_SLTI, OP_SLTIU: begin
                c[F_RW] = 1'b1; c[F_A] = 1'b1; c[F_SE] = 1'b1; c[F_MID +: 3] = ALU_SLT;
            end
            OP_ANDI:  begin c[F_RW] = 1'b1; c[F_A] = 1'b1; c[F_MID +: 3] = ALU_AND; end
            OP_ORI:   begin c[F_RW] = 1'b1; c[F_A] = 1'b1; c[F_MID +: 3] = ALU_OR;  end
            OP_XORI:  begin c[F_RW] = 1'b1; c[F_A] = 1'b1; c[F_MID +: 3] = ALU_XOR; end
            OP_LUI:   begin c[F_RW] = 1'b1; c[F_OUT +: 2] = OUT_LUI; end
            OP_LW:    begin
                c[F_RW] = 1'b1; c[F_A] = 1'b1; c[F_SE] = 1'b1; c[F_MR] = 1'b1; c[F_M2R] = 1'b1;
            end
            OP_SW:    begin c[F_A] = 1'b1; c[F_SE] = 1'b1; c[F_MW] = 1'b1; end
            default:  c[F_ILL] = trap;
        endcase
        decode = c;
    endfunction

endpackage

// File: rtl/pipe_ctrl_decoder_mult_busy_ctr.sv
// Multiplier busy counter: loads the multiply latency on start, then counts down to zero.
module mult_busy_ctr
    import ctrl_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = 4,
    parameter int unsigned CNT_W       = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             dec,
    output logic [CNT_W-1:0] value,
    output logic             busy
);

    logic [CNT_W-1:0] value_next;

    always_comb begin
        value_next = value;
        if (load) begin
            value_next = CNT_W'(MULT_CYCLES);
        end else if (dec && value != '0) begin
            value_next = value - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            value <= '0;
            busy  <= 1'b0;
        end else begin
            value <= value_next;
            busy  <= (value_next != '0);
        end
    end

endmodule

// File: rtl/pipe_ctrl_decoder.sv
// Registered ID->EX control decoder with valid/ready handshake, flush, and
// interlock of HI/LO users while the multiplier is busy.
module pipe_ctrl_decoder
    import ctrl_pkg::*;
#(
    parameter int unsigned MULT_CYCLES  = 4,
    parameter bit          ILLEGAL_TRAP = 1'b1,
    parameter int unsigned CNT_W        = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [OP_W-1:0]   id_op,
    input  logic [OP_W-1:0]   id_func,
    output logic              id_ready,
    input  logic              flush,
    input  logic              ex_ready,
    output logic              ex_valid,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic              mult_busy
);

    logic [CTRL_W-1:0] dec_ctrl;
    logic [CNT_W-1:0]  busy_value;
    logic              legal;
    logic              mult_class;
    logic              hazard;
    logic              accept;
    logic              mult_load;

    always_comb begin
        dec_ctrl   = decode(id_op, id_func, ILLEGAL_TRAP);
        legal      = is_legal(id_op);
        mult_class = is_mult_class(id_op, id_func);
        hazard     = (busy_value != '0) && mult_class && id_valid;
        id_ready   = (ex_ready || !ex_valid) && !hazard;
        accept     = id_valid && id_ready;
        mult_load  = accept && dec_ctrl[F_START] && !flush;
    end

    mult_busy_ctr #(
        .MULT_CYCLES (MULT_CYCLES),
        .CNT_W       (CNT_W)
    ) u_busy (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (mult_load),
        .dec   (1'b1),
        .value (busy_value),
        .busy  (mult_busy)
    );

    // ID/EX register; an illegal op is loaded as a non-valid slot carrying only illegal_op.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_valid <= 1'b0;
            ex_ctrl  <= '0;
        end else if (flush) begin
            ex_valid <= 1'b0;
            ex_ctrl  <= '0;
        end else if (accept) begin
            ex_valid <= legal;
            ex_ctrl  <= dec_ctrl;
        end else if (ex_ready) begin
            ex_valid <= 1'b0;
            ex_ctrl  <= '0;
        end
    end

endmodule

// File: tb/tb_pipe_ctrl_decoder.sv
// Directed bench for pipe_ctrl_decoder: decode table vectors plus handshake,
// interlock, flush and reset sequences; two instances cover both trap settings.
module tb_pipe_ctrl_decoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic [5:0]  id_op;
    logic [5:0]  id_func;
    logic        flush;
    logic        ex_ready;
    logic        id_ready, id_ready0;
    logic        ex_valid, ex_valid0;
    logic [17:0] ex_ctrl, ex_ctrl0;
    logic        mult_busy, mult_busy0;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pipe_ctrl_decoder #(.MULT_CYCLES(4), .ILLEGAL_TRAP(1'b1), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_op(id_op), .id_func(id_func),
        .id_ready(id_ready), .flush(flush), .ex_ready(ex_ready), .ex_valid(ex_valid),
        .ex_ctrl(ex_ctrl), .mult_busy(mult_busy)
    );

    pipe_ctrl_decoder #(.MULT_CYCLES(4), .ILLEGAL_TRAP(1'b0), .CNT_W(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_op(id_op), .id_func(id_func),
        .id_ready(id_ready0), .flush(flush), .ex_ready(ex_ready), .ex_valid(ex_valid0),
        .ex_ctrl(ex_ctrl0), .mult_busy(mult_busy0)
    );

    typedef struct {
        logic [5:0]  op;
        logic [5:0]  func;
        logic [17:0] exp_ctrl;
        logic        exp_valid;
        logic [17:0] exp_ctrl0;
    } vec_t;

    vec_t vecs[18];

    function automatic logic [17:0] mk(input bit rw, input bit rd, input bit a, input bit [2:0] mid,
                                       input bit mw, input bit mr, input bit m2r, input bit bq,
                                       input bit bn, input bit j, input bit se, input bit [1:0] out,
                                       input bit st, input bit sg, input bit il);
        return {rw, rd, a, mid, mw, mr, m2r, bq, bn, j, se, out, st, sg, il};
    endfunction

    task automatic chk1(input string name, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk18(input string name, input logic [17:0] act, input logic [17:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [5:0] op, input logic [5:0] fn);
        id_valid = v;
        id_op    = op;
        id_func  = fn;
        #1;
    endtask

    logic [17:0] c_addi, c_lw, c_ori, c_mult, c_multu, c_mfhi, c_mflo, c_ill;

    initial begin
        c_addi  = mk(1,0,1,3'b000,0,0,0,0,0,0,1,2'b00,0,0,0);
        c_lw    = mk(1,0,1,3'b000,0,1,1,0,0,0,1,2'b00,0,0,0);
        c_ori   = mk(1,0,1,3'b011,0,0,0,0,0,0,0,2'b00,0,0,0);
        c_mult  = mk(0,0,0,3'b000,0,0,0,0,0,0,0,2'b00,1,1,0);
        c_multu = mk(0,0,0,3'b000,0,0,0,0,0,0,0,2'b00,1,0,0);
        c_mfhi  = mk(1,1,0,3'b000,0,0,0,0,0,0,0,2'b11,0,0,0);
        c_mflo  = mk(1,1,0,3'b000,0,0,0,0,0,0,0,2'b10,0,0,0);
        c_ill   = 18'h00001;

        vecs[0]  = '{6'h08, 6'h00, c_addi, 1'b1, c_addi};
        vecs[1]  = '{6'h23, 6'h00, c_lw, 1'b1, c_lw};
        vecs[2]  = '{6'h00, 6'h20, mk(1,1,0,3'b111,0,0,0,0,0,0,0,2'b00,0,0,0), 1'b1,
                     mk(1,1,0,3'b111,0,0,0,0,0,0,0,2'b00,0,0,0)};
        vecs[3]  = '{6'h00, 6'h10, c_mfhi, 1'b1, c_mfhi};
        vecs[4]  = '{6'h00, 6'h12, c_mflo, 1'b1, c_mflo};
        vecs[5]  = '{6'h00, 6'h00, 18'h0, 1'b1, 18'h0};
        vecs[6]  = '{6'h02, 6'h00, mk(0,0,0,3'b000,0,0,0,0,0,1,0,2'b00,0,0,0), 1'b1,
                     mk(0,0,0,3'b000,0,0,0,0,0,1,0,2'b00,0,0,0)};
        vecs[7]  = '{6'h04, 6'h00, mk(0,0,0,3'b000,0,0,0,1,0,0,0,2'b00,0,0,0), 1'b1,
                     mk(0,0,0,3'b000,0,0,0,1,0,0,0,2'b00,0,0,0)};
        vecs[8]  = '{6'h05, 6'h00, mk(0,0,0,3'b000,0,0,0,0,1,0,0,2'b00,0,0,0), 1'b1,
                     mk(0,0,0,3'b000,0,0,0,0,1,0,0,2'b00,0,0,0)};
        vecs[9]  = '{6'h09, 6'h00, c_addi, 1'b1, c_addi};
        vecs[10] = '{6'h0A, 6'h00, mk(1,0,1,3'b101,0,0,0,0,0,0,1,2'b00,0,0,0), 1'b1,
                     mk(1,0,1,3'b101,0,0,0,0,0,0,1,2'b00,0,0,0)};
        vecs[11] = '{6'h0C, 6'h00, mk(1,0,1,3'b010,0,0,0,0,0,0,0,2'b00,0,0,0), 1'b1,
                     mk(1,0,1,3'b010,0,0,0,0,0,0,0,2'b00,0,0,0)};
        vecs[12] = '{6'h0E, 6'h00, mk(1,0,1,3'b100,0,0,0,0,0,0,0,2'b00,0,0,0), 1'b1,
                     mk(1,0,1,3'b100,0,0,0,0,0,0,0,2'b00,0,0,0)};
        vecs[13] = '{6'h0F, 6'h00, mk(1,0,0,3'b000,0,0,0,0,0,0,0,2'b01,0,0,0), 1'b1,
                     mk(1,0,0,3'b000,0,0,0,0,0,0,0,2'b01,0,0,0)};
        vecs[14] = '{6'h2B, 6'h00, mk(0,0,1,3'b000,1,0,0,0,0,0,1,2'b00,0,0,0), 1'b1,
                     mk(0,0,1,3'b000,1,0,0,0,0,0,1,2'b00,0,0,0)};
        vecs[15] = '{6'h3F, 6'h00, c_ill, 1'b0, 18'h0};
        vecs[16] = '{6'h0B, 6'h00, mk(1,0,1,3'b101,0,0,0,0,0,0,1,2'b00,0,0,0), 1'b1,
                     mk(1,0,1,3'b101,0,0,0,0,0,0,1,2'b00,0,0,0)};
        vecs[17] = '{6'h01, 6'h00, c_ill, 1'b0, 18'h0};

        // Reset held two cycles with a live ADDI in ID
        rst_n = 1'b0; flush = 1'b0; ex_ready = 1'b1;
        drive(1'b1, 6'h08, 6'h00);
        tick(); tick();
        chk1("reset ex_valid", ex_valid, 1'b0);
        chk18("reset ex_ctrl", ex_ctrl, 18'h0);
        chk1("reset mult_busy", mult_busy, 1'b0);
        chk1("reset id_ready", id_ready, 1'b1);

        // Decode table, one instruction per cycle with EX always ready
        rst_n = 1'b1;
        for (int i = 0; i < 18; i++) begin
            drive(1'b1, vecs[i].op, vecs[i].func);
            chk1($sformatf("vec%0d id_ready", i), id_ready, 1'b1);
            tick();
            chk1($sformatf("vec%0d ex_valid", i), ex_valid, vecs[i].exp_valid);
            chk18($sformatf("vec%0d ex_ctrl", i), ex_ctrl, vecs[i].exp_ctrl);
            chk1($sformatf("vec%0d ex_valid notrap", i), ex_valid0, vecs[i].exp_valid);
            chk18($sformatf("vec%0d ex_ctrl notrap", i), ex_ctrl0, vecs[i].exp_ctrl0);
        end
        // Illegal pulse lasts one cycle
        drive(1'b0, 6'h00, 6'h00);
        tick();
        chk18("illegal pulse cleared", ex_ctrl, 18'h0);

        // EX stall with ORI held in ID/EX
        drive(1'b1, 6'h0D, 6'h00);
        tick();
        chk18("ori loaded", ex_ctrl, c_ori);
        ex_ready = 1'b0;
        drive(1'b1, 6'h08, 6'h00);
        for (int k = 0; k < 3; k++) begin
            chk1($sformatf("stall%0d id_ready", k), id_ready, 1'b0);
            tick();
            chk1($sformatf("stall%0d ex_valid", k), ex_valid, 1'b1);
            chk18($sformatf("stall%0d ex_ctrl", k), ex_ctrl, c_ori);
        end
        ex_ready = 1'b1;
        #1;
        chk1("resume id_ready", id_ready, 1'b1);
        tick();
        chk18("resume addi", ex_ctrl, c_addi);
        chk1("resume ex_valid", ex_valid, 1'b1);
        drive(1'b0, 6'h00, 6'h00);
        tick();
        chk1("resume no duplicate", ex_valid, 1'b0);

        // MULT then MFLO: interlock until the counter drains
        drive(1'b1, 6'h00, 6'h18);
        chk1("mult id_ready", id_ready, 1'b1);
        tick();
        drive(1'b1, 6'h00, 6'h12);
        for (int k = 1; k <= 5; k++) begin
            chk1($sformatf("mflo t%0d id_ready", k), id_ready, k == 5);
            chk1($sformatf("mflo t%0d ex_valid", k), ex_valid, k == 1);
            chk1($sformatf("mflo t%0d start_mult", k), ex_ctrl[2], k == 1);
            chk1($sformatf("mflo t%0d mult_busy", k), mult_busy, k <= 4);
            if (k == 1) chk18("mult ex_ctrl", ex_ctrl, c_mult);
            tick();
        end
        chk1("mflo accepted ex_valid", ex_valid, 1'b1);
        chk18("mflo accepted ex_ctrl", ex_ctrl, c_mflo);
        drive(1'b0, 6'h00, 6'h00);
        tick();

        // Flush kills MULTU in ID and does not start the multiplier
        flush = 1'b1;
        drive(1'b1, 6'h00, 6'h19);
        tick();
        chk1("flush mult ex_valid", ex_valid, 1'b0);
        chk18("flush mult ex_ctrl", ex_ctrl, 18'h0);
        chk1("flush mult busy", mult_busy, 1'b0);
        flush = 1'b0;
        #1;
        tick();
        chk18("multu ex_ctrl", ex_ctrl, c_multu);
        chk1("multu busy", mult_busy, 1'b1);
        drive(1'b0, 6'h00, 6'h00);
        tick(); tick();
        // Counter now at 2; flush must not clear it
        flush = 1'b1;
        drive(1'b1, 6'h00, 6'h10);
        chk1("busy2 mfhi id_ready", id_ready, 1'b0);
        tick();
        flush = 1'b0;
        #1;
        chk1("busy1 mult_busy", mult_busy, 1'b1);
        chk1("busy1 mfhi id_ready", id_ready, 1'b0);
        chk1("busy1 ex_valid", ex_valid, 1'b0);
        tick();
        chk1("busy0 mult_busy", mult_busy, 1'b0);
        chk1("busy0 mfhi id_ready", id_ready, 1'b1);
        tick();
        chk18("busy0 mfhi ex_ctrl", ex_ctrl, c_mfhi);

        // Reset mid-multiply leaves no stale stall
        drive(1'b1, 6'h00, 6'h18);
        tick();
        chk1("pre-reset busy", mult_busy, 1'b1);
        rst_n = 1'b0;
        drive(1'b0, 6'h00, 6'h00);
        tick();
        rst_n = 1'b1;
        drive(1'b1, 6'h00, 6'h10);
        chk1("post-reset busy", mult_busy, 1'b0);
        chk1("post-reset ex_valid", ex_valid, 1'b0);
        chk1("post-reset mfhi id_ready", id_ready, 1'b1);
        tick();
        chk1("post-reset mfhi ex_valid", ex_valid, 1'b1);
        chk18("post-reset mfhi ex_ctrl", ex_ctrl, c_mfhi);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
